// File: rtl/prog_loader.sv
// Program-memory loader: assembles a big-endian byte stream into 32-bit words,
// writes them sequentially and holds the CPU in reset until a good checksum.
module prog_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [ADDR_W:0]   LEN,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DATA,
    output logic              MEM_WE,
    output logic              CPU_RST,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CSUM,
        FIN
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ADDR_W-1:0] last, last_n;
    logic [1:0]        cnt, cnt_n;
    logic [7:0]        sum, sum_n;
    logic [31:0]       shift, shift_n;
    logic              err_n;
    logic              take;
    logic              busy_n;
    logic [7:0]        csum;
    logic [ADDR_W:0]   len_m1;

    assign take   = BYTE_VALID && BYTE_READY;
    assign csum   = sum + BYTE_IN;
    assign len_m1 = LEN - 1'b1;
    assign busy_n = (state_n == RECV) || (state_n == WRITE) || (state_n == CSUM);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last;
        cnt_n   = cnt;
        sum_n   = sum;
        shift_n = shift;
        err_n   = ERR;
        unique case (state)
            IDLE: begin
                if (START) begin
                    state_n = RECV;
                    idx_n   = '0;
                    cnt_n   = '0;
                    sum_n   = '0;
                    err_n   = 1'b0;
                    // Zero or oversize lengths mean a full-memory load.
                    if (LEN == '0 || LEN > (ADDR_W+1)'(DEPTH))
                        last_n = ADDR_W'(DEPTH - 1);
                    else
                        last_n = len_m1[ADDR_W-1:0];
                end
            end
            RECV: begin
                if (take) begin
                    shift_n = {shift[23:0], BYTE_IN};
                    sum_n   = csum;
                    cnt_n   = cnt + 2'd1;
                    if (cnt == 2'd3)
                        state_n = WRITE;
                end
            end
            WRITE: begin
                if (idx == last) begin
                    state_n = CSUM;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = RECV;
                end
            end
            CSUM: begin
                if (take) begin
                    err_n   = (csum != 8'd0);
                    state_n = FIN;
                end
            end
            FIN: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            idx        <= '0;
            last       <= '0;
            cnt        <= '0;
            sum        <= '0;
            shift      <= '0;
            BYTE_READY <= 1'b0;
            MEM_ADDR   <= '0;
            MEM_DATA   <= '0;
            MEM_WE     <= 1'b0;
            CPU_RST    <= 1'b1;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            last       <= last_n;
            cnt        <= cnt_n;
            sum        <= sum_n;
            shift      <= shift_n;
            BYTE_READY <= (state_n == RECV) || (state_n == CSUM);
            MEM_WE     <= (state_n == WRITE);
            if (state_n == WRITE) begin
                MEM_ADDR <= idx_n;
                MEM_DATA <= shift_n;
            end
            BUSY       <= busy_n;
            DONE       <= (state_n == FIN);
            ERR        <= err_n;
            CPU_RST    <= busy_n ? 1'b1 : err_n;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against a word/checksum reference model.
module tb_prog_loader;

    localparam int AW = 5;
    localparam int D  = 32;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          START = 1'b0;
    logic [AW:0]   LEN = '0;
    logic [7:0]    BYTE_IN = '0;
    logic          BYTE_VALID = 1'b0;
    logic          BYTE_READY;
    logic [AW-1:0] MEM_ADDR;
    logic [31:0]   MEM_DATA;
    logic          MEM_WE;
    logic          CPU_RST;
    logic          BUSY;
    logic          DONE;
    logic          ERR;

    prog_loader #(.ADDR_W(AW), .DEPTH(D)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN),
        .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WE(MEM_WE),
        .CPU_RST(CPU_RST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Write/DONE monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) begin
            wa.push_back(MEM_ADDR);
            wd.push_back(MEM_DATA);
        end
        if (DONE === 1'b1) done_cnt++;
    end

    task automatic stream(input logic [7:0] b[$], input bit bp, input bit glitch, output bit ok);
        int i = 0;
        int cyc = 0;
        while (i < b.size() && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            START = glitch && ($urandom_range(0, 7) == 0);
            LEN   = (AW+1)'($urandom);
            BYTE_VALID = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            BYTE_IN = BYTE_VALID ? b[i] : 8'($urandom);
            if (BYTE_VALID && BYTE_READY) i++;
        end
        ok = (i == b.size());
    endtask

    task automatic do_load(input int len, input logic [7:0] b[$], input bit bp,
                           input bit glitch, input string tag);
        int L;
        int s;
        bit exp_err;
        bit ok;
        int base;
        int dbase;
        logic [31:0] w;
        L = (len == 0 || len > D) ? D : len;
        s = 0;
        foreach (b[k]) s += int'(b[k]);
        exp_err = (s % 256) != 0;
        base  = wa.size();
        dbase = done_cnt;
        @(negedge CLK);
        START = 1'b1;
        LEN   = (AW+1)'(len);
        @(negedge CLK);
        START = 1'b0;
        check({tag, ".busy_start"}, 32'(BUSY), 32'd1);
        check({tag, ".rdy_start"}, 32'(BYTE_READY), 32'd1);
        check({tag, ".cpurst_start"}, 32'(CPU_RST), 32'd1);
        stream(b, bp, glitch, ok);
        check({tag, ".stream_done"}, 32'(ok), 32'd1);
        @(negedge CLK);
        BYTE_VALID = 1'b0;
        START = 1'b0;
        check({tag, ".done"}, 32'(DONE), 32'd1);
        check({tag, ".busy_fin"}, 32'(BUSY), 32'd0);
        check({tag, ".err"}, 32'(ERR), 32'(exp_err));
        check({tag, ".cpurst_fin"}, 32'(CPU_RST), 32'(exp_err));
        @(negedge CLK);
        #1;
        check({tag, ".done_pulse"}, 32'(DONE), 32'd0);
        check({tag, ".cpurst_idle"}, 32'(CPU_RST), 32'(exp_err));
        check({tag, ".done_cnt"}, 32'(done_cnt - dbase), 32'd1);
        check({tag, ".nwrites"}, 32'(wa.size() - base), 32'(L));
        for (int k = 0; k < L && base + k < wa.size(); k++) begin
            w = {b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]};
            check($sformatf("%s.addr%0d", tag, k), 32'(wa[base+k]), 32'(k));
            check($sformatf("%s.data%0d", tag, k), wd[base+k], w);
        end
    endtask

    function automatic int fix_csum(input logic [7:0] b[$]);
        int s = 0;
        foreach (b[k]) s += int'(b[k]);
        return (256 - (s % 256)) % 256;
    endfunction

    initial begin
        logic [7:0] g[$];
        logic [7:0] bad[$];
        logic [7:0] full[$];
        logic [7:0] part[$];
        logic [7:0] r[$];
        bit ok;
        int len;
        int L;
        int base;

        g = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hC8};
        bad = g;
        bad[8] = 8'h00;

        repeat (3) begin
            @(negedge CLK);
            check("rst.cpurst", 32'(CPU_RST), 32'd1);
            check("rst.rdy", 32'(BYTE_READY), 32'd0);
            check("rst.we", 32'(MEM_WE), 32'd0);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst.cpurst_rel", 32'(CPU_RST), 32'd0);
        repeat (4) @(negedge CLK);
        #1;
        check("idle.rdy", 32'(BYTE_READY), 32'd0);
        check("idle.nwrites", 32'(wa.size()), 32'd0);

        do_load(2, g, 1'b0, 1'b0, "good");
        do_load(2, bad, 1'b0, 1'b0, "bad");
        repeat (3) @(negedge CLK);
        check("bad.err_sticky", 32'(ERR), 32'd1);
        check("bad.cpurst_held", 32'(CPU_RST), 32'd1);
        do_load(2, g, 1'b0, 1'b0, "recover");

        for (int i = 0; i < 128; i++) full.push_back(8'(i));
        full.push_back(8'(fix_csum(full)));
        do_load(0, full, 1'b0, 1'b0, "full");
        check("full.last_word", wd[wd.size()-1], 32'h7C7D7E7F);

        do_load(2, g, 1'b1, 1'b1, "bp");

        for (int i = 0; i < 6; i++) part.push_back(g[i]);
        @(negedge CLK);
        START = 1'b1;
        LEN = 6'd2;
        @(negedge CLK);
        START = 1'b0;
        stream(part, 1'b0, 1'b0, ok);
        check("mid.stream", 32'(ok), 32'd1);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("mid.rdy", 32'(BYTE_READY), 32'd0);
        check("mid.addr", 32'(MEM_ADDR), 32'd0);
        check("mid.data", MEM_DATA, 32'd0);
        check("mid.we", 32'(MEM_WE), 32'd0);
        check("mid.busy", 32'(BUSY), 32'd0);
        check("mid.done", 32'(DONE), 32'd0);
        check("mid.err", 32'(ERR), 32'd0);
        check("mid.cpurst", 32'(CPU_RST), 32'd1);
        BYTE_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        do_load(2, g, 1'b0, 1'b0, "reload");

        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(0, 63);
            L = (len == 0 || len > D) ? D : len;
            r.delete();
            for (int i = 0; i < 4 * L; i++) r.push_back(8'($urandom));
            if ($urandom_range(0, 1) == 1) r.push_back(8'(fix_csum(r)));
            else r.push_back(8'($urandom));
            do_load(len, r, 1'b1, 1'b1, $sformatf("rnd%0d", t));
        end

        base = 0;
        foreach (wa[k]) if (wa[k] > AW'(D - 1)) base++;
        check("no_oob", 32'(base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory loader: the write-side counterpart to the instruction-fetch path. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into the 32-word program memory through its `addr`/`data_in`/`write` port. It holds the CPU in reset while loading and releases it only after a successful checksum.

## Interface

Parameters:
- `ADDR_W`, default 5: program memory address width.
- `DEPTH`, default 32: number of words in program memory. Must equal 2^`ADDR_W`.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `START`  in  1  begins a load when the block is in IDLE; ignored in any other state.
- `LEN`  in  `ADDR_W`+1  number of words to load, sampled on START. A value of 0 or greater than `DEPTH` means `DEPTH`.
- `BYTE_IN`  in  8  stream data byte.
- `BYTE_VALID`  in  1  `BYTE_IN` is valid.
- `BYTE_READY`  out  1  loader accepts a byte this cycle (registered).
- `MEM_ADDR`  out  `ADDR_W`  program memory write address.
- `MEM_DATA`  out  32  program memory write data.
- `MEM_WE`  out  1  program memory write strobe; one cycle per word.
- `CPU_RST`  out  1  active-high reset to the CPU / fetch counter.
- `BUSY`  out  1  a load is in progress.
- `DONE`  out  1  one-cycle pulse when a load completes.
- `ERR`  out  1  checksum failure; sticky until the next START.

## Operation

- States: IDLE, RECV, WRITE, CSUM, FIN.
- **IDLE**
  - `BYTE_READY`=0 and `BUSY`=0.
  - `CPU_RST` equals `ERR`.
  - When START=1: latch the effective length L, clear the word index, byte count (0..3) and 8-bit sum, clear `ERR`, and go to RECV.
- **RECV**
  - `BYTE_READY`=1 and `BUSY`=1.
  - A byte is accepted only on a cycle where `BYTE_VALID`=1 and `BYTE_READY`=1.
  - On accept: shift register ← {shift[23:0], `BYTE_IN`}, so the first byte lands in bits 31:24. The sum ← (sum + `BYTE_IN`) mod 256.
  - On the 4th accepted byte, go to WRITE.
- **WRITE**
  - `BYTE_READY`=0.
  - `MEM_WE`=1 for exactly this cycle, with `MEM_ADDR` = word index and `MEM_DATA` = assembled word.
  - If word index = L−1, go to CSUM. Otherwise increment the word index and return to RECV.
  - The word index never exceeds `DEPTH`−1, so there is no wrap-around.
- **CSUM**
  - `BYTE_READY`=1; accept one byte.
  - If (sum + byte) mod 256 ≠ 0, set `ERR`=1.
  - Go to FIN.
- **FIN**
  - `DONE`=1 and `BUSY`=0; return to IDLE.
  - `CPU_RST` follows `ERR`: it deasserts on a good load and stays asserted on a bad one.
- `CPU_RST`=1 throughout RECV, WRITE and CSUM.
- START outside IDLE is ignored. Bytes presented while `BYTE_READY`=0 are not consumed.
- An `RST_N` assertion mid-load aborts the load immediately. Words already written remain in memory; the remaining contents are undefined to software. The next START restarts at address 0.

## Timing

- All outputs are registered.
- Reset values: `BYTE_READY`=0, `MEM_ADDR`=0, `MEM_DATA`=0, `MEM_WE`=0, `BUSY`=0, `DONE`=0, `ERR`=0, `CPU_RST`=1.
- `CPU_RST` falls on the first rising `CLK` edge after `RST_N` releases, because the block enters IDLE with `ERR`=0.
- START sampled at edge N:
  - `BUSY`=1, `CPU_RST`=1 and `BYTE_READY`=1 from cycle N+1.
- 4th byte of a word accepted at edge M:
  - WRITE state (with `MEM_WE`=1) in cycle M+1.
  - `BYTE_READY` back to 1 in cycle M+2.
  - Minimum 5 cycles per word.
- Checksum byte accepted at edge K:
  - `DONE`=1, `BUSY`=0 and final `ERR`/`CPU_RST` in cycle K+1.
  - IDLE in cycle K+2.
- Minimum total load time: 5·L + 3 cycles.

## Test plan

- **Reset/idle:** hold `RST_N`=0 for 3 cycles, then release.
  - Required: `CPU_RST`=1 during reset and 0 one cycle after release.
  - Required: `MEM_WE` never asserts and `BYTE_READY` stays 0.
- **Good load:** LEN=2, bytes 12 34 56 78 9A BC DE F0, checksum C8.
  - Required: writes 0x12345678 to address 0 and 0x9ABCDEF0 to address 1.
  - Required: `DONE` pulses once, `ERR`=0, `CPU_RST` falls with `DONE`.
- **Bad checksum:** same stream with checksum 00.
  - Required: both words written, `DONE` pulses, `ERR`=1, `CPU_RST` stays 1.
  - Required: a following good load clears `ERR` and releases `CPU_RST`.
- **Full depth:** LEN=0, 128 bytes with byte i = i, then the correct checksum.
  - Required: 32 writes at addresses 0..31 in order; address 31 = 0x7C7D7E7F.
  - Required: no write beyond address 31.
- **Backpressure and START:** `BYTE_VALID` toggled randomly, and START pulsed mid-load.
  - Required: identical memory contents to the good load.
  - Required: no byte accepted while `BYTE_READY`=0, and the mid-load START has no effect.
- **Reset mid-load:** assert `RST_N` after 6 bytes of a LEN=2 load.
  - Required: all outputs take reset values asynchronously.
  - Required: a new START reloads from address 0 correctly.
